// File: rtl/alu_pkg.sv
// Shared encodings for the ALU request scheduler: request op codes, ALU bus
// op encodings and scheduler FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADDSUB = 2'b00,
    ALU_AND    = 2'b01,
    ALU_XOR    = 2'b10,
    ALU_SHIFT  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_EXEC   = 3'd2,
    ST_FLAGS  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic logic is_reserved(input op_e op);
    return (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

  function automatic alu_op_e alu_op_of(input op_e op);
    alu_op_e r;
    case (op)
      OP_ADD, OP_SUB: r = ALU_ADDSUB;
      OP_AND:         r = ALU_AND;
      OP_XOR:         r = ALU_XOR;
      OP_SHL, OP_SHR: r = ALU_SHIFT;
      default:        r = ALU_ADDSUB;
    endcase
    return r;
  endfunction

  // Shared direction line: 1 selects subtract for add/sub and left for shifts.
  function automatic logic sub_shift_dir_of(input op_e op);
    return (op == OP_SUB) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority passes to the other
// requester whenever a grant is issued.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // ptr_q names the requester that wins when both are requesting.
  logic ptr_q, ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
    ptr_d = ptr_q;
    if (o_gnt[0]) begin
      ptr_d = 1'b1;
    end else if (o_gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules requests from two clients onto a shared external ALU, one
// operation in flight, and returns result plus flags to the owning client.
module alu_sched
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [2:0]  i_req_op0,
  input  logic [2:0]  i_req_op1,
  input  logic [7:0]  i_req_a0,
  input  logic [7:0]  i_req_a1,
  input  logic [7:0]  i_req_b0,
  input  logic [7:0]  i_req_b1,
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [7:0]  o_rsp_y,
  output logic        o_rsp_n,
  output logic        o_rsp_z,
  output logic        o_rsp_err,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic        o_alu_bWr,
  output logic        o_alu_oe,
  output logic        o_alu_subShiftDir,
  output logic [1:0]  o_alu_op,
  input  logic [7:0]  i_alu_y,
  input  logic        i_alu_negative,
  input  logic        i_alu_zero,
  output logic [15:0] o_ops_done
);

  state_e      state_q, state_d;
  logic        id_q, id_d;
  op_e         op_q, op_d;
  logic [7:0]  a_q, a_d, b_q, b_d, y_q, y_d;
  logic        n_q, n_d, z_q, z_d, err_q, err_d;
  logic [15:0] ops_done_q, ops_done_d;
  logic [1:0]  gnt;
  logic        arb_en;

  // No grant is offered in a reset cycle so nothing is acknowledged and then lost.
  assign arb_en = (state_q == ST_IDLE) && !i_reset;

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (arb_en),
    .i_req   (i_req_valid),
    .o_gnt   (gnt)
  );

  assign o_req_ready = gnt;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    y_d        = y_q;
    n_d        = n_q;
    z_d        = z_q;
    err_d      = err_q;
    ops_done_d = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          id_d = gnt[1];
          op_d = gnt[1] ? op_e'(i_req_op1) : op_e'(i_req_op0);
          a_d  = gnt[1] ? i_req_a1 : i_req_a0;
          b_d  = gnt[1] ? i_req_b1 : i_req_b0;
          // Reserved ops never touch the ALU and answer with a fixed error result.
          if (is_reserved(op_d)) begin
            y_d     = 8'h00;
            n_d     = 1'b0;
            z_d     = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_LOAD_B;
          end
        end
      end
      ST_LOAD_B: state_d = ST_EXEC;
      ST_EXEC: begin
        y_d     = i_alu_y;
        state_d = ST_FLAGS;
      end
      ST_FLAGS: begin
        n_d     = i_alu_negative;
        z_d     = i_alu_zero;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready[id_q]) begin
          state_d    = ST_IDLE;
          ops_done_d = ops_done_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      id_q       <= 1'b0;
      op_q       <= OP_ADD;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      y_q        <= 8'h00;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      err_q      <= 1'b0;
      ops_done_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      y_q        <= y_d;
      n_q        <= n_d;
      z_q        <= z_d;
      err_q      <= err_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign o_alu_bWr         = (state_q == ST_LOAD_B);
  assign o_alu_b           = o_alu_bWr ? b_q : 8'h00;
  assign o_alu_oe          = (state_q == ST_EXEC);
  assign o_alu_a           = o_alu_oe ? a_q : 8'h00;
  assign o_alu_op          = o_alu_oe ? alu_op_of(op_q) : ALU_ADDSUB;
  assign o_alu_subShiftDir = o_alu_oe && sub_shift_dir_of(op_q);

  assign o_rsp_valid = (state_q == ST_RESP) ? {id_q, ~id_q} : 2'b00;
  assign o_rsp_y     = (state_q == ST_RESP) ? y_q : 8'h00;
  assign o_rsp_n     = (state_q == ST_RESP) && n_q;
  assign o_rsp_z     = (state_q == ST_RESP) && z_q;
  assign o_rsp_err   = (state_q == ST_RESP) && err_q;
  assign o_ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: external ALU model, cycle monitor with an
// arithmetic reference, directed vector table and random traffic.
module tb_alu_sched;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req_valid, o_req_ready;
  logic [2:0]  i_req_op0, i_req_op1;
  logic [7:0]  i_req_a0, i_req_a1, i_req_b0, i_req_b1;
  logic [1:0]  o_rsp_valid, i_rsp_ready;
  logic [7:0]  o_rsp_y;
  logic        o_rsp_n, o_rsp_z, o_rsp_err;
  logic [7:0]  o_alu_a, o_alu_b, i_alu_y;
  logic        o_alu_bWr, o_alu_oe, o_alu_subShiftDir;
  logic [1:0]  o_alu_op;
  logic        i_alu_negative = 1'b0;
  logic        i_alu_zero = 1'b0;
  logic [15:0] o_ops_done;

  always #5 i_clk = ~i_clk;

  alu_sched dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_op0         (i_req_op0),
    .i_req_op1         (i_req_op1),
    .i_req_a0          (i_req_a0),
    .i_req_a1          (i_req_a1),
    .i_req_b0          (i_req_b0),
    .i_req_b1          (i_req_b1),
    .o_rsp_valid       (o_rsp_valid),
    .i_rsp_ready       (i_rsp_ready),
    .o_rsp_y           (o_rsp_y),
    .o_rsp_n           (o_rsp_n),
    .o_rsp_z           (o_rsp_z),
    .o_rsp_err         (o_rsp_err),
    .o_alu_a           (o_alu_a),
    .o_alu_b           (o_alu_b),
    .o_alu_bWr         (o_alu_bWr),
    .o_alu_oe          (o_alu_oe),
    .o_alu_subShiftDir (o_alu_subShiftDir),
    .o_alu_op          (o_alu_op),
    .i_alu_y           (i_alu_y),
    .i_alu_negative    (i_alu_negative),
    .i_alu_zero        (i_alu_zero),
    .o_ops_done        (o_ops_done)
  );

  // External ALU: b register written by bWr, combinational result on oe,
  // flags registered one cycle after oe.
  logic [7:0] alu_breg = 8'h00;
  logic [7:0] alu_res;

  always_comb begin
    alu_res = 8'h00;
    case (o_alu_op)
      2'b00: alu_res = o_alu_subShiftDir ? (o_alu_a - alu_breg) : (o_alu_a + alu_breg);
      2'b01: alu_res = o_alu_a & alu_breg;
      2'b10: alu_res = o_alu_a ^ alu_breg;
      default: alu_res = o_alu_subShiftDir ? (o_alu_a << alu_breg[2:0]) : (o_alu_a >> alu_breg[2:0]);
    endcase
  end

  assign i_alu_y = o_alu_oe ? alu_res : 8'h00;

  always @(posedge i_clk) begin
    if (o_alu_bWr) alu_breg <= o_alu_b;
    if (o_alu_oe) begin
      i_alu_negative <= alu_res[7];
      i_alu_zero     <= (alu_res == 8'h00);
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endfunction

  // Reference result as {err, n, z, y}, from the op-code definitions.
  function automatic logic [10:0] ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    case (op)
      3'd0: y = a + b;
      3'd1: y = a - b;
      3'd2: y = a & b;
      3'd3: y = a ^ b;
      3'd4: y = a << b[2:0];
      3'd5: y = a >> b[2:0];
      default: return {1'b1, 1'b0, 1'b1, 8'h00};
    endcase
    return {1'b0, y[7], (y == 8'h00), y};
  endfunction

  // Cycle monitor: expected grant, ALU strobes, response timing/fields, counter.
  initial begin
    bit          busy = 0;
    bit          rsv = 0;
    bit          last_gnt = 1;
    logic        id = 1'b0;
    int          acc_cyc = 0;
    logic [7:0]  acc_a = 8'h00, acc_b = 8'h00;
    logic [10:0] exp_rsp = '0;
    logic [15:0] mdone = 16'h0000;
    logic [1:0]  eg, erv;
    logic        ebw, eoe, rv_on, hs;
    logic [2:0]  gop;
    forever begin
      @(negedge i_clk);
      cyc++;
      eg = 2'b00;
      if (!busy && !i_reset && i_req_valid != 2'b00) begin
        if (i_req_valid == 2'b11) eg = last_gnt ? 2'b01 : 2'b10;
        else eg = i_req_valid;
      end
      chk("req_ready", 32'(o_req_ready), 32'(eg));
      ebw = busy && !rsv && (cyc == acc_cyc + 1);
      eoe = busy && !rsv && (cyc == acc_cyc + 2);
      chk("alu_bWr", 32'(o_alu_bWr), 32'(ebw));
      chk("alu_oe", 32'(o_alu_oe), 32'(eoe));
      chk("alu_b", 32'(o_alu_b), ebw ? 32'(acc_b) : 32'h0);
      chk("alu_a", 32'(o_alu_a), eoe ? 32'(acc_a) : 32'h0);
      rv_on = busy && (cyc >= acc_cyc + (rsv ? 1 : 4));
      erv = rv_on ? (id ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_valid", 32'(o_rsp_valid), 32'(erv));
      if (rv_on) chk("rsp_fields", 32'({o_rsp_err, o_rsp_n, o_rsp_z, o_rsp_y}), 32'(exp_rsp));
      chk("ops_done", 32'(o_ops_done), 32'(mdone));
      hs = rv_on && i_rsp_ready[id];
      if (i_reset) begin
        busy = 0;
        mdone = 16'h0000;
        last_gnt = 1;
      end else begin
        if (hs) begin
          busy = 0;
          mdone = mdone + 16'd1;
        end
        if (eg != 2'b00) begin
          busy = 1;
          acc_cyc = cyc;
          id = eg[1];
          gop = eg[1] ? i_req_op1 : i_req_op0;
          acc_a = eg[1] ? i_req_a1 : i_req_a0;
          acc_b = eg[1] ? i_req_b1 : i_req_b0;
          rsv = (gop[2] && gop[1]);
          exp_rsp = ref_rsp(gop, acc_a, acc_b);
          last_gnt = eg[1];
        end
      end
    end
  end

  typedef struct {
    int         req;
    logic [2:0] op;
    logic [7:0] a, b, y;
    logic       n, z, err;
    int         lat;
  } vec_t;

  vec_t tab[10];

  task automatic set_req(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (r == 0) begin
      i_req_op0 = op; i_req_a0 = a; i_req_b0 = b;
    end else begin
      i_req_op1 = op; i_req_a1 = a; i_req_b1 = b;
    end
  endtask

  // Single request with immediate response accept; checks latency and result.
  task automatic run_one(input vec_t v, input int idx);
    bit acc = 0;
    int lat = 0;
    @(posedge i_clk); #1;
    set_req(v.req, v.op, v.a, v.b);
    i_req_valid = (v.req == 0) ? 2'b01 : 2'b10;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_req_ready[v.req]) begin acc = 1; break; end
    end
    @(posedge i_clk); #1;
    i_req_valid = 2'b00;
    if (!acc) begin
      fail_now($sformatf("vec%0d_accept", idx));
      return;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid[v.req]) begin lat = k; break; end
    end
    chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("vec%0d_y", idx), 32'(o_rsp_y), 32'(v.y));
    chk($sformatf("vec%0d_n", idx), 32'(o_rsp_n), 32'(v.n));
    chk($sformatf("vec%0d_z", idx), 32'(o_rsp_z), 32'(v.z));
    chk($sformatf("vec%0d_err", idx), 32'(o_rsp_err), 32'(v.err));
    $display("vec %0d: req%0d op=%0d a=%02h b=%02h -> y=%02h n=%0b z=%0b err=%0b lat=%0d",
             idx, v.req, v.op, v.a, v.b, o_rsp_y, o_rsp_n, o_rsp_z, o_rsp_err, lat);
  endtask

  initial begin
    int  got;
    bit  seen;
    tab[0] = '{0, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 4};
    tab[1] = '{1, 3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 4};
    tab[2] = '{1, 3'b100, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 4};
    tab[3] = '{1, 3'b101, 8'h80, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 4};
    tab[4] = '{0, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 4};
    tab[5] = '{0, 3'b011, 8'hAA, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b0, 4};
    tab[6] = '{0, 3'b110, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    tab[7] = '{1, 3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    tab[8] = '{1, 3'b001, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 4};
    tab[9] = '{0, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 4};

    i_reset = 1'b1;
    i_req_valid = 2'b00;
    i_rsp_ready = 2'b11;
    set_req(0, 3'b000, 8'h00, 8'h00);
    set_req(1, 3'b000, 8'h00, 8'h00);
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("reset_ops_done", 32'(o_ops_done), 32'h0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'h0);

    // Both requesters busy from reset: grants must alternate starting with 0.
    @(posedge i_clk); #1;
    set_req(0, 3'b000, 8'h11, 8'h22);
    set_req(1, 3'b011, 8'h0F, 8'hF0);
    i_req_valid = 2'b11;
    got = 0;
    for (int k = 0; k < 100 && got < 8; k++) begin
      @(negedge i_clk);
      if (o_req_ready != 2'b00) begin
        chk($sformatf("rr_grant%0d", got), 32'(o_req_ready), (got % 2 == 1) ? 32'h2 : 32'h1);
        got++;
      end
    end
    @(posedge i_clk); #1;
    i_req_valid = 2'b00;
    if (got < 8) fail_now("rr_grants");
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_ops_done == 16'd8) break;
    end
    chk("rr_ops_done", 32'(o_ops_done), 32'd8);

    for (int i = 0; i < 10; i++) run_one(tab[i], i);

    // Response held off: fields stay put, no grant to the waiting requester.
    @(posedge i_clk); #1;
    i_rsp_ready = 2'b00;
    set_req(0, 3'b000, 8'h10, 8'h20);
    i_req_valid = 2'b01;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_req_ready[0]) begin seen = 1; break; end
    end
    if (!seen) fail_now("hold_accept");
    @(posedge i_clk); #1;
    set_req(1, 3'b001, 8'h09, 8'h04);
    i_req_valid = 2'b10;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid[0]) begin seen = 1; break; end
    end
    if (!seen) fail_now("hold_rsp");
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      chk("hold_valid", 32'(o_rsp_valid), 32'h1);
      chk("hold_y", 32'(o_rsp_y), 32'h30);
      chk("hold_ready", 32'(o_req_ready), 32'h0);
      chk("hold_strobes", 32'({o_alu_bWr, o_alu_oe}), 32'h0);
    end
    @(posedge i_clk); #1;
    i_rsp_ready = 2'b10;
    repeat (3) begin
      @(negedge i_clk);
      chk("nonowner_ready_ignored", 32'(o_rsp_valid), 32'h1);
    end
    @(posedge i_clk); #1;
    i_rsp_ready = 2'b11;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (o_req_ready[1]) begin seen = 1; break; end
    end
    if (!seen) fail_now("hold_second_grant");
    @(posedge i_clk); #1;
    i_req_valid = 2'b00;
    repeat (8) @(posedge i_clk);

    // Reset while the ALU is executing: abandoned, then a normal op works.
    #1;
    set_req(0, 3'b000, 8'h33, 8'h44);
    i_req_valid = 2'b01;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_req_ready[0]) begin seen = 1; break; end
    end
    if (!seen) fail_now("rst_accept");
    @(posedge i_clk); #1;
    i_req_valid = 2'b00;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rst_in_exec_oe", 32'(o_alu_oe), 32'h1);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      chk("rst_no_rsp", 32'(o_rsp_valid), 32'h0);
      chk("rst_no_oe", 32'(o_alu_oe), 32'h0);
    end
    chk("rst_ops_done", 32'(o_ops_done), 32'h0);
    run_one(tab[0], 0);

    // Random traffic, checked by the monitor.
    for (int k = 0; k < 1500; k++) begin
      @(posedge i_clk); #1;
      i_req_valid = 2'($urandom);
      set_req(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      set_req(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      i_rsp_ready = 2'($urandom);
      i_reset = ($urandom_range(0, 199) == 0);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_req_valid = 2'b00;
    i_rsp_ready = 2'b11;
    repeat (20) @(posedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have ports: i_reset  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: i_req_valid  in  2  per-requester request valid.
REQ-004 SHALL have ports: o_req_ready  out  2  per-requester accept strobe, one-hot or zero.
REQ-005 SHALL have ports: i_req_op0, i_req_op1  in  3 each  op code; 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SHL, 101 SHR, 110/111 reserved.
REQ-006 SHALL have ports: i_req_a0, i_req_a1, i_req_b0, i_req_b1  in  8 each  operands; shift count is b[2:0].
REQ-007 SHALL have ports: o_rsp_valid  out  2  per-requester response valid.
REQ-008 SHALL have ports: i_rsp_ready  in  2  per-requester response accept.
REQ-009 SHALL have ports: o_rsp_y  out  8  result; o_rsp_n, o_rsp_z, o_rsp_err  out  1 each  negative, zero, reserved-op flags.
REQ-010 SHALL have ports: o_alu_a, o_alu_b  out  8  ALU operand buses; o_alu_bWr, o_alu_oe, o_alu_subShiftDir  out  1; o_alu_op  out  2.
REQ-011 SHALL have ports: i_alu_y  in  8  ALU result bus; i_alu_negative, i_alu_zero  in  1  registered ALU flags.
REQ-012 SHALL have ports: o_ops_done  out  16  completed-operation counter.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD_B -> EXEC -> FLAGS -> RESP -> IDLE; one operation in flight.
REQ-014 In IDLE with any i_req_valid set, SHALL grant one requester, assert its o_req_ready for that cycle only, and latch op, a, b and requester id.
REQ-015 Arbitration SHALL be round-robin: the requester not granted last wins a tie; after reset requester 0 has priority.
REQ-016 LOAD_B SHALL drive o_alu_b = latched b and o_alu_bWr = 1 for exactly one cycle.
REQ-017 EXEC SHALL drive o_alu_a = latched a, o_alu_oe = 1, o_alu_op/o_alu_subShiftDir per op (ADD 00/0, SUB 00/1, AND 01/x, XOR 10/x, SHL 11/1, SHR 11/0), and capture i_alu_y.
REQ-018 FLAGS SHALL capture i_alu_negative and i_alu_zero (valid the cycle after oe).
REQ-019 RESP SHALL hold o_rsp_valid[id] = 1 with stable y/n/z/err until i_rsp_ready[id] = 1, then return to IDLE the next cycle.
REQ-020 Latency: request accepted in cycle T SHALL give o_rsp_valid in T+4 at earliest; throughput one op per 5 cycles with immediate ready.
REQ-021 Reserved op SHALL be accepted, SHALL skip LOAD_B/EXEC/FLAGS (no ALU strobes), and respond in T+1 with y=0x00, n=0, z=1, err=1.
REQ-022 o_alu_bWr and o_alu_oe SHALL be 0 outside LOAD_B and EXEC respectively; o_alu_a/o_alu_b SHALL be 0x00 when not driven.
REQ-023 Requests arriving outside IDLE SHALL wait; o_req_ready SHALL be 0 outside IDLE.
REQ-024 i_rsp_ready on the non-owning port SHALL be ignored.
REQ-025 o_ops_done SHALL increment by 1 on each response handshake, wrapping 0xFFFF -> 0x0000.

Reset
REQ-026 i_reset SHALL force IDLE, all outputs 0, o_ops_done 0, round-robin pointer to requester 0.
REQ-027 Reset in any state SHALL abandon the in-flight operation without a response.
REQ-028 Reset SHALL take priority over every simultaneous event.

Structure
REQ-029 Op-code enum, ALU op encodings and FSM state enum SHALL reside in shared package alu_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arb2 (2 request in, 2 one-hot grant out, pointer update on grant).
REQ-031 Implementation SHALL be fully synchronous, single clock, no latches.

Verification
REQ-032 Req0 ADD a=0x7F b=0x01 -> bWr in T+1, oe in T+2, rsp in T+4 with y=0x80 n=1 z=0 err=0.
REQ-033 Req1 SUB a=0x05 b=0x05 -> y=0x00 z=1 n=0; then SHL a=0x81 b=0x01 -> y=0x02; SHR a=0x80 b=0x0F -> y=0x01.
REQ-034 Both valid from reset, 4 ops each -> grants alternate 0,1,0,1,...; o_ops_done = 8.
REQ-035 i_rsp_ready held 0 for 10 cycles -> rsp fields stable, no new grant, no ALU strobes.
REQ-036 i_reset during EXEC -> next cycle IDLE, no o_rsp_valid, oe=0; following op completes normally.
REQ-037 Op 110 -> no bWr/oe pulses, rsp at T+1 with err=1 y=0x00 z=1.
